// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read port and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int width     = 8,
    parameter int depth     = 8,
    parameter int n         = $clog2(depth),
    parameter int afull_th  = depth - 2,
    parameter int aempty_th = 1,
    parameter int fwft      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [width-1:0] wdata,
    input  logic             rinc,
    output logic [width-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             afull,
    output logic             aempty,
    output logic [n:0]       count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam logic [n:0] full_lvl   = (n+1)'(depth);
    localparam logic [n:0] afull_lvl  = (n+1)'(afull_th);
    localparam logic [n:0] aempty_lvl = (n+1)'(aempty_th);

    logic [width-1:0] mem [depth];
    logic [n:0]       wptr;
    logic [n:0]       rptr;
    logic             wr_en;
    logic             rd_en;

    // Flags come only from registered pointers, so full/empty seen by the
    // request qualifiers below are the pre-edge values.
    assign count  = wptr - rptr;
    assign wfull  = (count == full_lvl);
    assign rempty = (count == '0);
    assign afull  = (count >= afull_lvl);
    assign aempty = (count <= aempty_lvl);

    assign wr_en = winc && !wfull;
    assign rd_en = rinc && !rempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wptr[n-1:0]] <= wdata;
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)  overflow <= 1'b1;
            else if (err_clr)   overflow <= 1'b0;
            if (rinc && rempty) underflow <= 1'b1;
            else if (err_clr)   underflow <= 1'b0;
        end
    end

    generate
        if (fwft != 0) begin : g_fwft
            assign rdata = mem[rptr[n-1:0]];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst)        rdata <= '0;
                else if (rd_en) rdata <= mem[rptr[n-1:0]];
            end
        end
    endgenerate

endmodule
